// File: rtl/i2c_bit_timer.sv
// I2C bit timer: turns a 4x-SCL phase reference into a four-quarter SCL bit with SDA change/sample strobes.
// Define I2C_STRETCH_TIMEOUT_EN to abort a bit when a slave stretches SCL for too long.
module i2c_bit_timer #(
  parameter int SYNC_STAGES           = 2,
  parameter int STRETCH_TIMEOUT_TICKS = 64
) (
  input  logic inputClock,
  input  logic reset,
  input  logic phaseClock,
  input  logic enable,
  input  logic sclIn,
  output logic sclDriveLow,
  output logic dataChangeStrobe,
  output logic dataSampleStrobe,
  output logic bitDone,
  output logic busy,
  output logic stretching,
  output logic timeoutError
);

  typedef enum logic [2:0] {IDLE, LOW1, LOW2, HIGH1, HIGH2} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] phase_sync;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic                   phase_hist;
  logic                   tick;
  logic                   scl_level;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STRETCH_TIMEOUT_TICKS < 1) begin : g_bad_params
    $error("i2c_bit_timer: illegal parameter value");
  end

  // Synchronizers reset high so a phaseClock already high at release is not mistaken for a rising edge.
  always_ff @(posedge inputClock or posedge reset) begin
    if (reset) begin
      phase_sync <= '1;
      scl_sync   <= '1;
      phase_hist <= 1'b1;
    end else begin
      phase_sync <= {phase_sync[SYNC_STAGES-2:0], phaseClock};
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], sclIn};
      phase_hist <= phase_sync[SYNC_STAGES-1];
    end
  end

  assign tick      = phase_sync[SYNC_STAGES-1] & ~phase_hist;
  assign scl_level = scl_sync[SYNC_STAGES-1];

`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam int CW = $clog2(STRETCH_TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STRETCH_TIMEOUT_TICKS);
  logic [CW-1:0] stretch_cnt;
`else
  assign timeoutError = 1'b0;
`endif

  always_ff @(posedge inputClock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      sclDriveLow      <= 1'b0;
      dataChangeStrobe <= 1'b0;
      dataSampleStrobe <= 1'b0;
      bitDone          <= 1'b0;
      busy             <= 1'b0;
      stretching       <= 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
      stretch_cnt      <= '0;
      timeoutError     <= 1'b0;
`endif
    end else begin
      dataChangeStrobe <= 1'b0;
      dataSampleStrobe <= 1'b0;
      bitDone          <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (enable) begin
              state       <= LOW1;
              sclDriveLow <= 1'b1;
              busy        <= 1'b1;
`ifdef I2C_STRETCH_TIMEOUT_EN
              timeoutError <= 1'b0;
`endif
            end
          end
          LOW1: begin
            state            <= LOW2;
            dataChangeStrobe <= 1'b1;
          end
          LOW2: begin
            state       <= HIGH1;
            sclDriveLow <= 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
            stretch_cnt <= '0;
`endif
          end
          HIGH1: begin
            // SCL only counts as high once the released line has been seen through the synchronizer.
            if (scl_level) begin
              state            <= HIGH2;
              dataSampleStrobe <= 1'b1;
              stretching       <= 1'b0;
            end else begin
`ifdef I2C_STRETCH_TIMEOUT_EN
              if (stretch_cnt == LIMIT - 1'b1) begin
                state        <= IDLE;
                busy         <= 1'b0;
                stretching   <= 1'b0;
                timeoutError <= 1'b1;
                stretch_cnt  <= LIMIT;
              end else begin
                stretching  <= 1'b1;
                stretch_cnt <= stretch_cnt + 1'b1;
              end
`else
              stretching <= 1'b1;
`endif
            end
          end
          HIGH2: begin
            bitDone <= 1'b1;
            if (enable) begin
              state       <= LOW1;
              sclDriveLow <= 1'b1;
            end else begin
              state       <= IDLE;
              sclDriveLow <= 1'b0;
              busy        <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_bit_timer.sv
// Testbench for i2c_bit_timer: directed scenarios plus random phase/enable/stretch traffic,
// all checked every cycle against a quarter-count model of the I2C bit.
module tb_i2c_bit_timer;

  localparam int S  = 2;
  localparam int TO = 4;
`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam int HOLD_TICKS = TO - 1;
`else
  localparam int HOLD_TICKS = 5;
`endif

  logic inputClock = 1'b0;
  logic reset, phaseClock, enable, slave_hold, sclIn;
  logic sclDriveLow, dataChangeStrobe, dataSampleStrobe, bitDone, busy, stretching, timeoutError;
  logic [6:0] dut_out, exp_out;

  int checks = 0;
  int errors = 0;

  // phase generator state
  int ph_hi = 4, ph_lo = 4, ph_left = 0;
  bit ph_run = 0;

  // reference model state
  bit ph_q[$];
  bit scl_q[$];
  int pos, scnt;
  bit m_tick, m_chg, m_smp, m_done, m_str, m_tmo;

  always #5 inputClock = ~inputClock;

  assign sclIn   = ~(sclDriveLow | slave_hold);
  assign dut_out = {sclDriveLow, dataChangeStrobe, dataSampleStrobe, bitDone, busy, stretching, timeoutError};

  i2c_bit_timer #(.SYNC_STAGES(S), .STRETCH_TIMEOUT_TICKS(TO)) dut (
    .inputClock(inputClock), .reset(reset), .phaseClock(phaseClock), .enable(enable), .sclIn(sclIn),
    .sclDriveLow(sclDriveLow), .dataChangeStrobe(dataChangeStrobe), .dataSampleStrobe(dataSampleStrobe),
    .bitDone(bitDone), .busy(busy), .stretching(stretching), .timeoutError(timeoutError)
  );

  function automatic void model_reset();
    pos = 0; scnt = 0;
    m_tick = 0; m_chg = 0; m_smp = 0; m_done = 0; m_str = 0; m_tmo = 0;
    ph_q.delete();
    scl_q.delete();
    for (int i = 0; i < S + 2; i++) begin
      ph_q.push_back(1'b1);
      scl_q.push_back(1'b1);
    end
    exp_out = '0;
  endfunction

  // pos = quarters of the current bit already started (0 = idle, 1..4); a tick advances one quarter
  // unless the bus is still held low at the start of the high half.
  function automatic void model_edge(bit en);
    int n = ph_q.size();
    bit scl_s = scl_q[n-1-S];
    m_tick = ph_q[n-1-S] && !ph_q[n-2-S];
    m_chg = 0; m_smp = 0; m_done = 0;
    if (m_tick) begin
      if (pos == 0) begin
        if (en) begin pos = 1; m_tmo = 0; end
      end else if (pos == 3 && !scl_s) begin
        m_str = 1;
        scnt++;
`ifdef I2C_STRETCH_TIMEOUT_EN
        if (scnt >= TO) begin pos = 0; m_str = 0; m_tmo = 1; end
`endif
      end else begin
        pos++;
        if (pos == 2) m_chg = 1;
        if (pos == 3) scnt = 0;
        if (pos == 4) begin m_smp = 1; m_str = 0; end
        if (pos == 5) begin m_done = 1; pos = en ? 1 : 0; end
      end
    end
    exp_out = {(pos == 1 || pos == 2), m_chg, m_smp, m_done, pos != 0, m_str, m_tmo};
    while (ph_q.size() > 16) void'(ph_q.pop_front());
    while (scl_q.size() > 16) void'(scl_q.pop_front());
  endfunction

  task automatic step();
    bit en_now;
    if (ph_run) begin
      if (ph_left == 0) begin
        phaseClock = ~phaseClock;
        ph_left = phaseClock ? ph_hi : ph_lo;
      end
      ph_left--;
    end
    #1;
    ph_q.push_back(phaseClock);
    scl_q.push_back(sclIn);
    en_now = enable;
    @(posedge inputClock);
    #1;
    model_edge(en_now);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge inputClock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    int lat;
    phaseClock = 1'b1; enable = 1'b1; slave_hold = 1'b0; ph_run = 0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (dut_out !== 7'b0) begin errors++; $display("FAIL reset_values: got %b expected 0000000", dut_out); end
    @(posedge inputClock);
    #1 reset = 1'b0;
    model_reset();
    repeat (40) begin
      step();
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_reset_hold t=%0t: got %b expected %b", $time, dut_out, exp_out); end
    end
    checks++;
    if (dut_out !== 7'b0) begin errors++; $display("FAIL no_tick_after_reset: got %b expected 0000000", dut_out); end
    phaseClock = 1'b0;
    repeat (4) step();
    phaseClock = 1'b1;
    lat = 0;
    while (sclDriveLow !== 1'b1 && lat < 20) begin
      step();
      lat++;
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_first_edge t=%0t: got %b expected %b", $time, dut_out, exp_out); end
    end
    checks++;
    if (lat != S + 1) begin errors++; $display("FAIL first_edge_latency: got %0d expected %0d", lat, S + 1); end
  endtask

  task automatic test_three_bits();
    int dones = 0, nchg = 0, nsmp = 0, low_cyc = 0, high_cyc = 0, cyc = 0;
    do_reset();
    ph_hi = 4; ph_lo = 4; ph_left = 0; ph_run = 1; enable = 1'b1; slave_hold = 1'b0;
    while (dones < 3 && cyc < 600) begin
      step();
      cyc++;
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_three_bits t=%0t: got %b expected %b", $time, dut_out, exp_out); end
      nchg += int'(dataChangeStrobe);
      nsmp += int'(dataSampleStrobe);
      if (busy && sclDriveLow) low_cyc++;
      if (busy && !sclDriveLow) high_cyc++;
      if (bitDone) begin
        dones++;
        if (dones == 3) begin
          checks++;
          if (busy !== 1'b0 || sclDriveLow !== 1'b0) begin
            errors++; $display("FAIL third_done_release: got busy=%b drive=%b expected 0 0", busy, sclDriveLow);
          end
        end
      end
      if (dones == 2 && dataChangeStrobe) enable = 1'b0;
    end
    checks++;
    if (dones != 3) begin errors++; $display("FAIL three_bits_done: got %0d expected 3", dones); end
    checks++;
    if (nchg != 3 || nsmp != 3) begin errors++; $display("FAIL strobe_counts: got chg=%0d smp=%0d expected 3 3", nchg, nsmp); end
    checks++;
    if (low_cyc != 48 || high_cyc != 48) begin
      errors++; $display("FAIL scl_duty: got low=%0d high=%0d expected 48 48", low_cyc, high_cyc);
    end
  endtask

  task automatic test_stretch();
    int ticks = 0, smp_held = 0, smp_after = 0, guard = 0;
    bit prev_drv = 0, got_done = 0;
    do_reset();
    enable = 1'b1; slave_hold = 1'b0;
    while (!(prev_drv && !sclDriveLow && busy) && guard < 200) begin
      prev_drv = sclDriveLow;
      step();
      guard++;
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_stretch_pre t=%0t: got %b expected %b", $time, dut_out, exp_out); end
    end
    slave_hold = 1'b1;
    guard = 0;
    while (ticks < HOLD_TICKS && guard < 200) begin
      step();
      guard++;
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_stretch_hold t=%0t: got %b expected %b", $time, dut_out, exp_out); end
      smp_held += int'(dataSampleStrobe);
      if (m_tick) begin
        ticks++;
        if (ticks == 1) begin
          checks++;
          if (stretching !== 1'b1) begin errors++; $display("FAIL stretch_first_tick: got %b expected 1", stretching); end
        end
      end
    end
    slave_hold = 1'b0;
    enable = 1'b0;
    guard = 0;
    while (!got_done && guard < 200) begin
      step();
      guard++;
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_stretch_post t=%0t: got %b expected %b", $time, dut_out, exp_out); end
      smp_after += int'(dataSampleStrobe);
      got_done = bitDone;
    end
    checks++;
    if (smp_held != 0) begin errors++; $display("FAIL sample_while_held: got %0d expected 0", smp_held); end
    checks++;
    if (!got_done || smp_after != 1) begin
      errors++; $display("FAIL stretch_completion: got done=%0d smp=%0d expected 1 1", got_done, smp_after);
    end
  endtask

`ifdef I2C_STRETCH_TIMEOUT_EN
  task automatic test_timeout();
    int ticks = 0, guard = 0, strobes = 0;
    bit prev_drv = 0;
    do_reset();
    enable = 1'b1; slave_hold = 1'b0;
    while (!(prev_drv && !sclDriveLow && busy) && guard < 200) begin
      prev_drv = sclDriveLow;
      step();
      guard++;
    end
    slave_hold = 1'b1;
    guard = 0;
    while (busy && guard < 300) begin
      step();
      guard++;
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_timeout t=%0t: got %b expected %b", $time, dut_out, exp_out); end
      if (m_tick) ticks++;
      strobes += int'(dataSampleStrobe) + int'(bitDone);
    end
    checks++;
    if (timeoutError !== 1'b1 || sclDriveLow !== 1'b0 || stretching !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: got tmo=%b drive=%b str=%b expected 1 0 0", timeoutError, sclDriveLow, stretching);
    end
    checks++;
    if (ticks != TO || strobes != 0) begin
      errors++; $display("FAIL timeout_ticks: got ticks=%0d strobes=%0d expected %0d 0", ticks, strobes, TO);
    end
    slave_hold = 1'b0;
    guard = 0;
    while (sclDriveLow !== 1'b1 && guard < 100) begin
      step();
      guard++;
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_timeout_restart t=%0t: got %b expected %b", $time, dut_out, exp_out); end
    end
    checks++;
    if (timeoutError !== 1'b0 || sclDriveLow !== 1'b1) begin
      errors++; $display("FAIL timeout_clear: got tmo=%b drive=%b expected 0 1", timeoutError, sclDriveLow);
    end
  endtask
`endif

  task automatic test_reset_midbit();
    int guard = 0;
    do_reset();
    enable = 1'b1; slave_hold = 1'b0;
    while (dataChangeStrobe !== 1'b1 && guard < 200) begin step(); guard++; end
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (dut_out !== 7'b0) begin errors++; $display("FAIL midbit_async_reset: got %b expected 0000000", dut_out); end
    @(posedge inputClock);
    #1;
    checks++;
    if (dut_out !== 7'b0) begin errors++; $display("FAIL midbit_reset_hold: got %b expected 0000000", dut_out); end
    reset = 1'b0;
    model_reset();
    guard = 0;
    while (!(dataChangeStrobe || dataSampleStrobe || bitDone) && guard < 100) begin
      step();
      guard++;
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_midbit t=%0t: got %b expected %b", $time, dut_out, exp_out); end
    end
    checks++;
    if (dataChangeStrobe !== 1'b1 || sclDriveLow !== 1'b1) begin
      errors++; $display("FAIL restart_from_low1: got chg=%b drive=%b expected 1 1", dataChangeStrobe, sclDriveLow);
    end
  endtask

  task automatic test_enable_glitch();
    int guard = 0;
    do_reset();
    enable = 1'b1; slave_hold = 1'b0;
    while (sclDriveLow !== 1'b1 && guard < 100) begin step(); guard++; end
    enable = 1'b0;
    guard = 0;
    while (dataChangeStrobe !== 1'b1 && guard < 100) begin
      step();
      guard++;
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_glitch_low t=%0t: got %b expected %b", $time, dut_out, exp_out); end
    end
    enable = 1'b1;
    guard = 0;
    while (bitDone !== 1'b1 && guard < 100) begin
      step();
      guard++;
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_glitch_high t=%0t: got %b expected %b", $time, dut_out, exp_out); end
    end
    checks++;
    if (bitDone !== 1'b1 || busy !== 1'b1 || sclDriveLow !== 1'b1) begin
      errors++; $display("FAIL back_to_back: got done=%b busy=%b drive=%b expected 1 1 1", bitDone, busy, sclDriveLow);
    end
  endtask

  task automatic test_random();
    int hold_left = 0;
    do_reset();
    enable = 1'b1; slave_hold = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) begin ph_hi = $urandom_range(2, 6); ph_lo = $urandom_range(2, 6); end
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if (hold_left > 0) hold_left--;
      else if ($urandom_range(0, 29) == 0) hold_left = $urandom_range(1, 40);
      slave_hold = (hold_left > 0);
      step();
      checks++;
      if (dut_out !== exp_out) begin errors++; $display("FAIL model_random t=%0t: got %b expected %b", $time, dut_out, exp_out); end
      checks++;
      if (int'(dataChangeStrobe) + int'(dataSampleStrobe) + int'(bitDone) > 1) begin
        errors++; $display("FAIL one_strobe t=%0t: got chg=%b smp=%b done=%b expected at most one", $time, dataChangeStrobe, dataSampleStrobe, bitDone);
      end
    end
  endtask

  initial begin
    reset = 1'b0; phaseClock = 1'b1; enable = 1'b0; slave_hold = 1'b0;
    model_reset();
    test_reset();
    test_three_bits();
    test_stretch();
`ifdef I2C_STRETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midbit();
    test_enable_glitch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
